// File: rtl/dnn_layer_seq.sv
// -----------------------------------------------------------------------------
// dnn_layer_seq
//
// Time-multiplexed dense layer: computes N_OUT signed dot products of an N_IN
// element feature vector against an N_IN x N_OUT weight matrix. One input
// channel is consumed per cycle using N_OUT parallel multipliers; each result
// is saturated to the feature width DW and held under an output handshake.
//
// Optional feature (compile-time macro):
//   DNN_RELU_EN  - when defined, a negative saturated result is forced to 0.
//                  out_sat still reports whether clamping occurred.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   x_in       in   N_IN*DW        feature vector, element i at [i*DW +: DW]
//   w_in       in   N_IN*N_OUT*WW  weights, w[i][j] at [(i*N_OUT+j)*WW +: WW]
//   in_valid   in   x_in/w_in valid
//   in_ready   out  block can accept (combinational from state and out_ready)
//   out_data   out  N_OUT*DW       result j at [j*DW +: DW]
//   out_sat    out  N_OUT          bit j set if result j was clamped
//   out_valid  out  out_data/out_sat valid
//   out_ready  in   downstream accepts
// -----------------------------------------------------------------------------
module dnn_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DW    = 21,
  parameter int WW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DW-1:0]       x_in,
  input  logic [N_IN*N_OUT*WW-1:0] w_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_OUT*DW-1:0]      out_data,
  output logic [N_OUT-1:0]         out_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Accumulator is wide enough that summing N_IN full-width products can
  // never overflow, so saturation only has to happen once at the end.
  localparam int AW = DW + WW + $clog2(N_IN);
  localparam int PW = DW + WW;
  localparam int IW = $clog2(N_IN);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t state, state_next;

  logic [N_IN*DW-1:0]       x_reg;
  logic [N_IN*N_OUT*WW-1:0] w_reg;
  logic [IW-1:0]            idx;
  logic signed [AW-1:0]     acc      [N_OUT];
  logic signed [AW-1:0]     acc_next [N_OUT];
  logic signed [PW-1:0]     prod     [N_OUT];
  logic signed [DW-1:0]     x_e;
  logic signed [DW-1:0]     res      [N_OUT];
  logic [N_OUT-1:0]         res_sat;
  logic                     accept;
  logic                     last;

  assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept   = in_valid & in_ready;
  assign last     = (state == ACCUM) && (idx == IW'(N_IN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. From HOLD, a simultaneous output accept and input
  // accept goes straight back to ACCUM so streaming costs one extra cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (last)   state_next = HOLD;
      HOLD: begin
        if (out_ready) state_next = in_valid ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One MAC per output column for the current input channel, followed by
  // saturation (and optional ReLU) of the would-be final accumulator value.
  // The saturated value is only registered on the last ACCUM cycle.
  always_comb begin
    x_e     = x_reg[int'(idx)*DW +: DW];
    res_sat = '0;
    for (int j = 0; j < N_OUT; j++) begin
      prod[j]     = x_e * $signed(w_reg[(int'(idx)*N_OUT + j)*WW +: WW]);
      acc_next[j] = acc[j] + {{(AW-PW){prod[j][PW-1]}}, prod[j]};
      if (acc_next[j] > SAT_MAX) begin
        res[j]     = SAT_MAX[DW-1:0];
        res_sat[j] = 1'b1;
      end else if (acc_next[j] < SAT_MIN) begin
        res[j]     = SAT_MIN[DW-1:0];
        res_sat[j] = 1'b1;
      end else begin
        res[j]     = acc_next[j][DW-1:0];
      end
`ifdef DNN_RELU_EN
      if (res[j][DW-1]) res[j] = '0;
`endif
    end
  end

  // Datapath registers: capture operands on accept, accumulate during ACCUM,
  // publish results on the last channel and drop out_valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      w_reg     <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_sat   <= '0;
      out_valid <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      if (accept) begin
        x_reg <= x_in;
        w_reg <= w_in;
        idx   <= '0;
        for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
      end else if (state == ACCUM) begin
        idx <= last ? '0 : idx + IW'(1);
        for (int j = 0; j < N_OUT; j++) acc[j] <= acc_next[j];
      end

      if (last) begin
        for (int j = 0; j < N_OUT; j++) out_data[j*DW +: DW] <= res[j];
        out_sat   <= res_sat;
        out_valid <= 1'b1;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dnn_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_dnn_layer_seq
//
// Directed self-checking bench for dnn_layer_seq at default parameters.
// Expected values for the directed cases are hand-computed constants; the
// streaming case uses a small integer reference model. Honours DNN_RELU_EN.
// -----------------------------------------------------------------------------
module tb_dnn_layer_seq;

  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int DW    = 21;
  localparam int WW    = 5;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N_IN*DW-1:0]       x_in = '0;
  logic [N_IN*N_OUT*WW-1:0] w_in = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [N_OUT*DW-1:0]      out_data;
  logic [N_OUT-1:0]         out_sat;
  logic                     out_valid;
  logic                     out_ready = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  int mx [N_IN];
  int mw [N_IN][N_OUT];

  dnn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_OUT*DW-1:0] packOut(input int a0, input int a1,
                                                   input int a2, input int a3);
    logic [N_OUT*DW-1:0] p;
    p = '0;
    p[0*DW +: DW] = DW'(a0);
    p[1*DW +: DW] = DW'(a1);
    p[2*DW +: DW] = DW'(a2);
    p[3*DW +: DW] = DW'(a3);
    return p;
  endfunction

  // Pack the model arrays onto the DUT input buses.
  task automatic loadVec();
    for (int i = 0; i < N_IN; i++) begin
      x_in[i*DW +: DW] = DW'(mx[i]);
      for (int j = 0; j < N_OUT; j++) w_in[(i*N_OUT+j)*WW +: WW] = WW'(mw[i][j]);
    end
  endtask

  task automatic setX(input int a0, input int a1, input int a2, input int a3);
    mx[0] = a0; mx[1] = a1; mx[2] = a2; mx[3] = a3;
  endtask

  task automatic setWAll(input int v);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) mw[i][j] = v;
  endtask

  // Present a vector, let it be accepted on the next edge, then scramble the
  // input buses to prove the DUT captured them.
  task automatic applyStimulus();
    loadVec();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x_in = {$urandom, $urandom, $urandom};
    w_in = {$urandom, $urandom, $urandom};
  endtask

  // Wait (bounded) for out_valid; returns cycles since the accept edge or -1.
  task automatic waitValid(output int cycles);
    cycles = -1;
    for (int c = 1; c <= N_IN + 4; c++) begin
      tick();
      if (out_valid) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [N_OUT*DW-1:0] exp_data,
                             input logic [N_OUT-1:0] exp_sat);
    checkEq({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    checkEq({tag, "_data"}, 128'(out_data), 128'(exp_data));
    checkEq({tag, "_sat"}, 128'(out_sat), 128'(exp_sat));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Independent integer reference: dot product, clamp, optional ReLU.
  task automatic modelOut(output logic [N_OUT*DW-1:0] d, output logic [N_OUT-1:0] s);
    longint sum, lo, hi;
    lo = -(longint'(1) << (DW-1));
    hi = (longint'(1) << (DW-1)) - 1;
    d = '0;
    s = '0;
    for (int j = 0; j < N_OUT; j++) begin
      sum = 0;
      for (int i = 0; i < N_IN; i++) sum += longint'(mx[i]) * longint'(mw[i][j]);
      if (sum > hi) begin sum = hi; s[j] = 1'b1; end
      else if (sum < lo) begin sum = lo; s[j] = 1'b1; end
`ifdef DNN_RELU_EN
      if (sum < 0) sum = 0;
`endif
      d[j*DW +: DW] = DW'(sum);
    end
  endtask

  task automatic setStreamVec(input int k);
    for (int i = 0; i < N_IN; i++) begin
      mx[i] = k*1000 - i*317 + 5;
      for (int j = 0; j < N_OUT; j++) mw[i][j] = ((i*3 + j*5 + k*7) % 31) - 15;
    end
  endtask

  initial begin
    int lat;
    int k, next_k, last_cyc;
    bit need_load;
    logic [N_OUT*DW-1:0] md;
    logic [N_OUT-1:0]    ms;

    // ---------------- reset state ----------------
    tick();
    tick();
    checkEq("rst_in_ready", 128'(in_ready), 128'(1'b1));
    checkEq("rst_out_valid", 128'(out_valid), 128'(1'b0));
    checkEq("rst_out_data", 128'(out_data), 128'(0));
    checkEq("rst_out_sat", 128'(out_sat), 128'(0));
    rst_n = 1'b1;
    tick();

    // ---------------- basic ----------------
    setX(1, 2, 3, 4);
    setWAll(1);
    applyStimulus();
    checkEq("basic_in_ready_busy", 128'(in_ready), 128'(1'b0));
    waitValid(lat);
    checkEq("basic_latency", 128'(lat), 128'(N_IN));
    checkOutput("basic", packOut(10, 10, 10, 10), 4'b0000);
    consume();
    checkEq("basic_drop_valid", 128'(out_valid), 128'(1'b0));
    checkEq("basic_idle_ready", 128'(in_ready), 128'(1'b1));

    // ---------------- signed mix ----------------
    setX(-5, 7, 0, 100);
    setWAll(0);
`ifdef DNN_RELU_EN
    mw[0][0] = 16; mw[1][0] = -15; mw[2][0] = 3; mw[3][0] = -1;
`else
    mw[0][0] = -16; mw[1][0] = 15; mw[2][0] = 3; mw[3][0] = -1;
`endif
    applyStimulus();
    waitValid(lat);
    checkEq("mix_latency", 128'(lat), 128'(N_IN));
`ifdef DNN_RELU_EN
    checkOutput("mix", packOut(0, 0, 0, 0), 4'b0000);
`else
    checkOutput("mix", packOut(85, 0, 0, 0), 4'b0000);
`endif
    consume();

    // ---------------- saturation ----------------
    setX(1048575, 1048575, 1048575, 1048575);
    setWAll(0);
    for (int i = 0; i < N_IN; i++) begin
      mw[i][0] = -16;
      mw[i][1] = 15;
    end
    applyStimulus();
    waitValid(lat);
`ifdef DNN_RELU_EN
    checkOutput("sat", packOut(0, 1048575, 0, 0), 4'b0011);
`else
    checkOutput("sat", packOut(-1048576, 1048575, 0, 0), 4'b0011);
`endif
    consume();

    // ---------------- back-pressure ----------------
    setX(1, 2, 3, 4);
    setWAll(2);
    applyStimulus();
    waitValid(lat);
    checkOutput("bp_first", packOut(20, 20, 20, 20), 4'b0000);
    setX(3, -1, 2, 5);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) mw[i][j] = j + 1;
    loadVec();
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkEq("bp_in_ready", 128'(in_ready), 128'(1'b0));
      checkEq("bp_hold_data", 128'(out_data), 128'(packOut(20, 20, 20, 20)));
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkEq("bp_ready_comb", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkEq("bp_accept_same_edge", 128'(out_valid), 128'(1'b0));
    waitValid(lat);
    checkEq("bp_latency", 128'(lat), 128'(N_IN));
    checkOutput("bp_second", packOut(9, 18, 27, 36), 4'b0000);
    consume();

    // ---------------- back-to-back streaming ----------------
    out_ready = 1'b1;
    setStreamVec(0);
    loadVec();
    in_valid = 1'b1;
    tick();
    setStreamVec(1);
    loadVec();
    next_k    = 2;
    k         = 0;
    last_cyc  = 0;
    need_load = 1'b0;
    for (int cyc = 1; cyc <= 60 && k < 5; cyc++) begin
      tick();
      if (need_load) begin
        need_load = 1'b0;
        if (next_k < 5) begin
          setStreamVec(next_k);
          loadVec();
          next_k++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        setStreamVec(k);
        modelOut(md, ms);
        checkEq("stream_data", 128'(out_data), 128'(md));
        checkEq("stream_sat", 128'(out_sat), 128'(ms));
        if (k == 0) checkEq("stream_first_lat", 128'(cyc), 128'(N_IN));
        else        checkEq("stream_spacing", 128'(cyc - last_cyc), 128'(N_IN + 1));
        last_cyc  = cyc;
        need_load = 1'b1;
        k++;
      end
    end
    checkEq("stream_count", 128'(k), 128'(5));
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();

    // ---------------- reset mid-ACCUM ----------------
    setX(1048575, 1048575, 1048575, 1048575);
    setWAll(15);
    applyStimulus();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkEq("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    checkEq("midrst_out_data", 128'(out_data), 128'(0));
    checkEq("midrst_out_sat", 128'(out_sat), 128'(0));
    checkEq("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    tick();
    rst_n = 1'b1;
    tick();
    checkEq("midrst_no_output", 128'(out_valid), 128'(1'b0));
    setX(1, 2, 3, 4);
    setWAll(1);
    applyStimulus();
    waitValid(lat);
    checkEq("midrst_latency", 128'(lat), 128'(N_IN));
    checkOutput("midrst_after", packOut(10, 10, 10, 10), 4'b0000);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
